keypad_scan_fifo: RTL
=====================

Name: keypad_scan_fifo

Overview:
- Parametrised matrix-keypad scanner for ROWS x COLS active-low keypads.
- Drives the columns one-hot low and samples the rows.
- Debounces both press and release and offers optional auto-repeat.
- Queues key codes in a small FIFO with a valid/ready output handshake. It sits between the board keypad pins and the digit-entry/display logic, and supersedes the fixed 4x4 scanner.

Parameters:
- ROWS, 4, number of row inputs (2..8).
- COLS, 4, number of column outputs (2..8).
- SCAN_DIV, 4, clock cycles each column is held low; rows are sampled in the last cycle of the slot (settling time).
- DEBOUNCE_CYCLES, 20, consecutive identical row samples required to accept a press or a release (>=1).
- REPEAT_DELAY, 0, cycles of continuous hold before the first auto-repeat push; 0 disables auto-repeat.
- REPEAT_RATE, 0, cycles between subsequent auto-repeat pushes; ignored when REPEAT_DELAY=0; must be >=1 when enabled.
- DEPTH, 4, FIFO entries (power of two, >=2).
- CODE_W (localparam): clog2(ROWS*COLS).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- row_n, in, ROWS, keypad rows, active low, externally synchronised.
- col_n, out, COLS, column drive, one-hot low while scanning.
- out_code, out, CODE_W, key code at FIFO head.
- out_valid, out, 1, FIFO non-empty.
- out_ready, in, 1, consumer accepts out_code when out_valid=1.
- key_held, out, 1, debounced press is active.
- key_release, out, 1, one-cycle pulse on debounced release.
- multi_key, out, 1, one-cycle pulse when a sample shows more than one row low.
- overflow, out, 1, sticky; set when a push is dropped because the FIFO is full.

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=SCAN, col_idx=0, col_n=all ones, FIFO empty, out_valid=0, out_code=0.
  - key_held=0, key_release=0, multi_key=0, overflow=0.
  - All counters cleared.
  - On the first cycle after reset, col_n drives column 0.
  - Reset mid-press discards the press without pushing.
- Column mapping: col_idx k drives col_n[COLS-1-k] low. Row index r corresponds to row_n[ROWS-1-r].
- Code: code = col_idx*ROWS + r, a linear row-major index. With 4x4, the first column/first row gives 0 and the last column/last row gives 15.
- SCAN:
  - Hold the column for SCAN_DIV cycles, then sample.
  - Sample all ones: advance col_idx, wrapping COLS-1 to 0.
  - Exactly one row low: latch row pattern and code, set debounce count to 1, go to PRESS_DB. The column stays driven.
  - More than one row low: pulse multi_key, advance column, no capture.
- PRESS_DB:
  - Sample every cycle.
  - Sample equals the latched pattern: count increments. When count reaches DEBOUNCE_CYCLES, push code, set key_held=1, go to HELD.
  - Any other value: go back to SCAN on the next column with count cleared; nothing is pushed.
- HELD:
  - Column stays driven.
  - Any non-all-ones sample keeps HELD, including added keys; there is no second capture.
  - Sample all ones: go to REL_DB with count=1.
  - Auto-repeat (REPEAT_DELAY>0): the hold timer starts at press acceptance. The first extra push happens REPEAT_DELAY cycles later, then one push every REPEAT_RATE cycles while in HELD.
- REL_DB:
  - All-ones sample: count increments.
  - Non-all-ones sample: return to HELD; the repeat timer is not reset.
  - When count reaches DEBOUNCE_CYCLES: key_held=0, key_release pulses for 1 cycle, go to SCAN on the next column.
- FIFO:
  - Push and pop are registered. out_valid rises the cycle after the first push into an empty FIFO; there is no fall-through.
  - Pop occurs when out_valid && out_ready.
  - Push while full with no pop: data dropped, overflow set, held until rst.
  - Push while full with a simultaneous pop: both succeed.
  - Push while empty: no same-cycle pop possible.
  - out_code holds its value while out_valid=1 and out_ready=0.
- Latency (defaults): the press push is accepted DEBOUNCE_CYCLES-1 cycles after the detecting sample; out_valid follows 1 cycle later.

Test Plan:
- Defaults, out_ready=1. Hold row_n=4'b1011 only while col_n=4'b1101 (col_idx 2, r=1), stable for 40 cycles, then release. Required: exactly one out_code=9 handshake; key_held high from acceptance until release debounce; one key_release pulse; no multi_key.
- Bounce: toggle the row every 5 cycles for 60 cycles, then hold steady. Required: no push during toggling; exactly one push after 20 stable samples.
- row_n=4'b0011 at a sample. Required: multi_key pulses 1 cycle; scan advances; FIFO stays empty.
- DEPTH=4, out_ready=0, five distinct debounced presses. Required: codes 1–4 retained in order; the fifth is dropped; overflow=1. Then set out_ready=1: four pops; overflow stays 1.
- REPEAT_DELAY=50, REPEAT_RATE=10, hold code 5 for 100 cycles after acceptance. Required: pushes at acceptance, +50, +60, +70, +80, +90, +100, i.e. 7 entries of code 5 with out_ready=1.
- Assert rst during PRESS_DB at count 10. Required: col_n=all ones for the reset cycle, no push, key_held=0, scanning resumes at col_idx 0.

Source files
------------

// File: rtl/keypad_scan_fifo.sv
`default_nettype none
// keypad_scan_fifo: ROWS x COLS active-low keypad scanner with press/release debounce,
// optional auto-repeat and a registered key-code FIFO.  Rev 1.0
module keypad_scan_fifo #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_RATE     = 0,
  parameter int DEPTH           = 4,
  localparam int CODE_W         = $clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROWS-1:0]   row_n,
  output logic [COLS-1:0]   col_n,
  output logic [CODE_W-1:0] out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              key_held,
  output logic              key_release,
  output logic              multi_key,
  output logic              overflow
);

  localparam int CIDX_W  = $clog2(COLS);
  localparam int RIDX_W  = $clog2(ROWS);
  localparam int DIV_W   = $clog2(SCAN_DIV + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 2);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam bit REP_EN  = (REPEAT_DELAY > 0);
  localparam bit DB_ONE  = (DEBOUNCE_CYCLES <= 1);

  localparam logic [CIDX_W-1:0] COL_LAST  = CIDX_W'(COLS - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_ONE ? 0 : DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0]  DLY_LAST  = REP_W'(REP_EN ? REPEAT_DELAY - 1 : 0);
  localparam logic [REP_W-1:0]  RATE_LAST = REP_W'((REP_EN && REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);
  localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic                active;
  logic [CIDX_W-1:0]   col_idx, col_idx_nx, col_next;
  logic [DIV_W-1:0]    div_cnt, div_cnt_nx;
  logic [DB_W-1:0]     db_cnt, db_cnt_nx;
  logic [ROWS-1:0]     pattern, pattern_nx;
  logic [CODE_W-1:0]   code, code_nx, sample_code, push_code;
  logic                held_nx, multi_nx, accept, release_ev, rep_fire, push;
  logic [REP_W-1:0]    rep_cnt, rep_target;
  logic                rep_first;
  logic [RIDX_W-1:0]   row_sel;
  logic [ROWS-1:0]     low;
  logic                rows_idle, rows_multi;

  logic [CODE_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      count;
  logic                full, pop, wr_en;

  // Row sample decode: row index r lives on row_n[ROWS-1-r]
  always_comb begin
    low        = ~row_n;
    rows_idle  = (low == '0);
    rows_multi = !rows_idle && ((low & (low - 1'b1)) != '0);
    row_sel    = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (low[ROWS-1-r]) row_sel = RIDX_W'(r);
    end
    sample_code = CODE_W'(col_idx) * CODE_W'(ROWS) + CODE_W'(row_sel);
    col_next    = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
  end

  always_comb begin
    col_n = '1;
    for (int k = 0; k < COLS; k++) begin
      if (active && (col_idx == CIDX_W'(k))) col_n[COLS-1-k] = 1'b0;
    end
  end

  always_comb begin
    state_nx   = state;
    col_idx_nx = col_idx;
    div_cnt_nx = div_cnt;
    db_cnt_nx  = db_cnt;
    pattern_nx = pattern;
    code_nx    = code;
    held_nx    = key_held;
    multi_nx   = 1'b0;
    accept     = 1'b0;
    release_ev = 1'b0;
    case (state)
      SCAN: begin
        if (active) begin
          if (div_cnt == DIV_LAST) begin
            div_cnt_nx = '0;
            if (rows_idle || rows_multi) begin
              col_idx_nx = col_next;
              multi_nx   = rows_multi;
            end else begin
              pattern_nx = row_n;
              code_nx    = sample_code;
              db_cnt_nx  = DB_W'(1);
              if (DB_ONE) accept = 1'b1;
              else        state_nx = PRESS_DB;
            end
          end else begin
            div_cnt_nx = div_cnt + 1'b1;
          end
        end
      end
      PRESS_DB: begin
        if (row_n == pattern) begin
          if (db_cnt == DB_LAST) accept = 1'b1;
          else                   db_cnt_nx = db_cnt + 1'b1;
        end else begin
          state_nx   = SCAN;
          col_idx_nx = col_next;
          db_cnt_nx  = '0;
        end
      end
      HELD: begin
        if (rows_idle) begin
          db_cnt_nx = DB_W'(1);
          if (DB_ONE) release_ev = 1'b1;
          else        state_nx = REL_DB;
        end
      end
      REL_DB: begin
        if (!rows_idle) begin
          state_nx  = HELD;
          db_cnt_nx = '0;
        end else if (db_cnt == DB_LAST) begin
          release_ev = 1'b1;
        end else begin
          db_cnt_nx = db_cnt + 1'b1;
        end
      end
      default: state_nx = SCAN;
    endcase
    if (accept) begin
      state_nx  = HELD;
      held_nx   = 1'b1;
      db_cnt_nx = '0;
    end
    if (release_ev) begin
      state_nx   = SCAN;
      held_nx    = 1'b0;
      col_idx_nx = col_next;
      div_cnt_nx = '0;
      db_cnt_nx  = '0;
    end
  end

  // Repeat timer keeps running through release bounces; pushes only while HELD
  always_comb begin
    rep_target = rep_first ? DLY_LAST : RATE_LAST;
    rep_fire   = REP_EN && (state == HELD) && (rep_cnt == rep_target);
    push       = accept || rep_fire;
    push_code  = code_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SCAN;
      active      <= 1'b0;
      col_idx     <= '0;
      div_cnt     <= '0;
      db_cnt      <= '0;
      pattern     <= '0;
      code        <= '0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
      multi_key   <= 1'b0;
    end else begin
      state       <= state_nx;
      active      <= 1'b1;
      col_idx     <= col_idx_nx;
      div_cnt     <= div_cnt_nx;
      db_cnt      <= db_cnt_nx;
      pattern     <= pattern_nx;
      code        <= code_nx;
      key_held    <= held_nx;
      key_release <= release_ev;
      multi_key   <= multi_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !REP_EN) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (accept) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (state == HELD || state == REL_DB) begin
      if (rep_cnt == rep_target) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

  // Registered FIFO: a full FIFO still accepts a push when the head pops the same cycle
  always_comb begin
    full  = (count == FIFO_FULL);
    pop   = out_valid && out_ready;
    wr_en = push && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_code;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (pop && !wr_en) count <= count - 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign out_valid = (count != '0);
  assign out_code  = mem[rd_ptr];

endmodule
`default_nettype wire
